cascade_master_seq: RTL and testbench

//  Master-side cascade transmitter for the 8259A PIC. Tracks the CPU INTA pulse train
//  and drives the acknowledged IR id on CAS[2:0] when that IR has a slave attached.
//  The slave-side CAS comparator consumes this id to release its vector.

---
 rtl/cascade_master_seq_if.sv | 26 ++
 rtl/cascade_master_seq.sv | 162 ++++++++++++++++
 tb/tb_cascade_master_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cascade_master_seq_if.sv
// Cascade master bus bundle: INTA/config inputs from the control logic, CAS/vector controls out.
// master = the cascade sequencer's view; slave = the surrounding control/pad logic.
interface cascade_master_seq_if;
    logic       inta_n;
    logic       sp_en_n;
    logic       sngl;
    logic [7:0] icw3;
    logic [2:0] ack_ir;
    logic       ack_valid;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       vec_oe;
    logic [1:0] vec_byte_sel;
    logic       cyc_done;
    logic       abort;

    modport master (
        input  inta_n, sp_en_n, sngl, icw3, ack_ir, ack_valid,
        output cas_out, cas_oe, vec_oe, vec_byte_sel, cyc_done, abort
    );

    modport slave (
        output inta_n, sp_en_n, sngl, icw3, ack_ir, ack_valid,
        input  cas_out, cas_oe, vec_oe, vec_byte_sel, cyc_done, abort
    );
endinterface

// File: rtl/cascade_master_seq.sv
// 8259A master cascade sequencer: follows the INTA pulse train, drives CAS and the vector release.
// Define CASCADE_8080_MODE_EN for the 3-pulse 8080 sequence; default is the 2-pulse 8086 sequence.
module cascade_master_seq #(
    parameter int GAP_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    cascade_master_seq_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        G1,
        P2,
`ifdef CASCADE_8080_MODE_EN
        G2,
        P3,
`endif
        DONE
    } state_t;

    localparam logic [TO_W-1:0] GAP_LIMIT = TO_W'(GAP_TIMEOUT);

    state_t          state_q, state_d;
    logic            inta_d_q;
    logic [2:0]      id_q, id_d;
    logic            hit_q, hit_d;
    logic            own_q, own_d;
    logic [TO_W-1:0] gap_cnt_q, gap_cnt_d;
    logic            abort_q, abort_d;

    logic            fall;
    logic            rise;
    logic [2:0]      id_sel;
    logic [TO_W-1:0] gap_inc;
    logic            gap_expired;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        hit_d       = hit_q;
        own_d       = own_q;
        gap_cnt_d   = gap_cnt_q;
        abort_d     = 1'b0;
        fall        = inta_d_q & ~bus.inta_n;
        rise        = ~inta_d_q & bus.inta_n;
        id_sel      = bus.ack_valid ? bus.ack_ir : 3'd7;
        gap_inc     = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;
        gap_expired = (GAP_TIMEOUT != 0) && (gap_inc == GAP_LIMIT);

        if (fall) begin
            gap_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                // Configuration is frozen here for the whole sequence.
                if (fall) begin
                    state_d = P1;
                    id_d    = id_sel;
                    hit_d   = bus.ack_valid & bus.icw3[id_sel] & bus.sp_en_n & ~bus.sngl;
                    own_d   = bus.sp_en_n | bus.sngl;
                end
            end
            P1: begin
                if (rise) begin
                    state_d = G1;
                end
            end
            G1: begin
                if (fall) begin
                    state_d = P2;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_expired) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end
                end
            end
            P2: begin
                if (rise) begin
`ifdef CASCADE_8080_MODE_EN
                    state_d = G2;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CASCADE_8080_MODE_EN
            G2: begin
                if (fall) begin
                    state_d = P3;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_expired) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end
                end
            end
            P3: begin
                if (rise) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inta_d_q  <= 1'b1;
            id_q      <= 3'd0;
            hit_q     <= 1'b0;
            own_q     <= 1'b0;
            gap_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inta_d_q  <= bus.inta_n;
            id_q      <= id_d;
            hit_q     <= hit_d;
            own_q     <= own_d;
            gap_cnt_q <= gap_cnt_d;
            abort_q   <= abort_d;
        end
    end

    logic       in_seq;
    logic       vec_phase;
    logic [1:0] byte_sel;

    // Outputs are pure functions of registered state, so they never glitch with inta_n.
    always_comb begin
        in_seq = (state_q != IDLE) && (state_q != DONE);
`ifdef CASCADE_8080_MODE_EN
        vec_phase = (state_q == P1) || (state_q == P2) || (state_q == P3);
        byte_sel  = (state_q == P2) ? 2'd1 : ((state_q == P3) ? 2'd2 : 2'd0);
`else
        vec_phase = (state_q == P2);
        byte_sel  = 2'd0;
`endif
    end

    assign bus.cas_oe       = in_seq & hit_q;
    assign bus.cas_out      = (in_seq & hit_q) ? id_q : 3'd0;
    assign bus.vec_oe       = vec_phase & own_q & ~hit_q;
    assign bus.vec_byte_sel = byte_sel;
    assign bus.cyc_done     = (state_q == DONE);
    assign bus.abort        = abort_q;

endmodule

// File: tb/tb_cascade_master_seq.sv
// Scoreboard bench for cascade_master_seq: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_cascade_master_seq;

    localparam int GAP = 8;
`ifdef CASCADE_8080_MODE_EN
    localparam bit MODE80 = 1'b1;
`else
    localparam bit MODE80 = 1'b0;
`endif
    localparam logic [8:0] Z = 9'd0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cascade_master_seq_if bus_if();

    cascade_master_seq #(
        .GAP_TIMEOUT (GAP),
        .TO_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [8:0] vec;
        int         test_id;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   test_id  = 0;
    int   cyc_idx  = 0;

    function automatic logic [8:0] pack(input logic [2:0] cas, input logic oe, input logic vec,
                                        input logic [1:0] sel, input logic done, input logic ab);
        return {cas, oe, vec, sel, done, ab};
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic inta, input logic [8:0] exp_v,
                                 input bit check);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = rst_v;
        bus_if.inta_n  = inta;
        if (check) begin
            e.vec     = exp_v;
            e.test_id = test_id;
            e.cyc     = cyc_idx;
            exp_q.push_back(e);
        end
        cyc_idx++;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] act;
        act = {bus_if.cas_out, bus_if.cas_oe, bus_if.vec_oe, bus_if.vec_byte_sel,
               bus_if.cyc_done, bus_if.abort};
        n_checks++;
        if (act !== e.vec) begin
            n_fail++;
            $display("[TB] FAIL test%0d cyc%0d outputs: actual cas=%0d oe=%b vec=%b sel=%0d done=%b abort=%b, required cas=%0d oe=%b vec=%b sel=%0d done=%b abort=%b",
                     e.test_id, e.cyc, act[8:6], act[5], act[4], act[3:2], act[1], act[0],
                     e.vec[8:6], e.vec[5], e.vec[4], e.vec[3:2], e.vec[1], e.vec[0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // One full INTA sequence; config inputs are scrambled after entry to prove they are latched.
    task automatic runSeq(input logic [2:0] ir, input logic av, input logic [7:0] icw,
                          input logic spn, input logic sg, input logic [2:0] e_cas,
                          input logic e_oe, input logic e_vec, input int gap_len,
                          input bit fall_in_done);
        logic [8:0] busy, p1, p2, p3, done_v;
        busy   = pack(e_cas, e_oe, 1'b0, 2'd0, 1'b0, 1'b0);
        p1     = pack(e_cas, e_oe, MODE80 ? e_vec : 1'b0, 2'd0, 1'b0, 1'b0);
        p2     = pack(e_cas, e_oe, e_vec, MODE80 ? 2'd1 : 2'd0, 1'b0, 1'b0);
        p3     = pack(e_cas, e_oe, e_vec, 2'd2, 1'b0, 1'b0);
        done_v = pack(3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        test_id++;
        bus_if.ack_ir    = ir;
        bus_if.ack_valid = av;
        bus_if.icw3      = icw;
        bus_if.sp_en_n   = spn;
        bus_if.sngl      = sg;
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, p1, 1'b1);
        bus_if.icw3      = ~icw;
        bus_if.sngl      = ~sg;
        bus_if.sp_en_n   = ~spn;
        bus_if.ack_ir    = ~ir;
        bus_if.ack_valid = ~av;
        applyStimulus(1'b0, 1'b1, p1, 1'b1);
        for (int i = 1; i < gap_len; i++) begin
            applyStimulus(1'b0, 1'b1, busy, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, busy, 1'b1);
        applyStimulus(1'b0, 1'b0, p2, 1'b1);
        applyStimulus(1'b0, 1'b1, p2, 1'b1);
`ifdef CASCADE_8080_MODE_EN
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        applyStimulus(1'b0, 1'b0, busy, 1'b1);
        applyStimulus(1'b0, 1'b0, p3, 1'b1);
        applyStimulus(1'b0, 1'b1, p3, 1'b1);
`endif
        if (fall_in_done) begin
            applyStimulus(1'b0, 1'b0, done_v, 1'b1);
            applyStimulus(1'b0, 1'b0, Z, 1'b1);
            applyStimulus(1'b0, 1'b1, Z, 1'b1);
        end else begin
            applyStimulus(1'b0, 1'b1, done_v, 1'b1);
            applyStimulus(1'b0, 1'b1, Z, 1'b1);
        end
    endtask

    task automatic runTimeout();
        logic [8:0] busy;
        busy = pack(3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        test_id++;
        bus_if.ack_ir    = 3'd2;
        bus_if.ack_valid = 1'b1;
        bus_if.icw3      = 8'h04;
        bus_if.sp_en_n   = 1'b1;
        bus_if.sngl      = 1'b0;
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, busy, 1'b1);
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        for (int i = 0; i < GAP; i++) begin
            applyStimulus(1'b0, 1'b1, busy, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, pack(3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1), 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
    endtask

    task automatic runReset();
        logic [8:0] busy, p2;
        busy = pack(3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        p2   = pack(3'd2, 1'b1, 1'b0, MODE80 ? 2'd1 : 2'd0, 1'b0, 1'b0);
        test_id++;
        bus_if.ack_ir    = 3'd2;
        bus_if.ack_valid = 1'b1;
        bus_if.icw3      = 8'h04;
        bus_if.sp_en_n   = 1'b1;
        bus_if.sngl      = 1'b0;
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, Z, 1'b1);
        applyStimulus(1'b0, 1'b0, busy, 1'b1);
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        applyStimulus(1'b0, 1'b1, busy, 1'b1);
        applyStimulus(1'b0, 1'b0, busy, 1'b1);
        applyStimulus(1'b1, 1'b0, p2, 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        // Reset coinciding with a falling INTA in IDLE must not start a sequence.
        applyStimulus(1'b1, 1'b0, Z, 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus_if.inta_n    = 1'b1;
        bus_if.sp_en_n   = 1'b1;
        bus_if.sngl      = 1'b0;
        bus_if.icw3      = 8'h00;
        bus_if.ack_ir    = 3'd0;
        bus_if.ack_valid = 1'b0;

        applyStimulus(1'b1, 1'b1, Z, 1'b0);
        applyStimulus(1'b1, 1'b1, Z, 1'b1);
        applyStimulus(1'b0, 1'b1, Z, 1'b1);

        runSeq(3'd2, 1'b1, 8'h04, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 3, 1'b0);
        runSeq(3'd5, 1'b1, 8'h04, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3, 1'b0);
        runSeq(3'd7, 1'b0, 8'h80, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3, 1'b0);
        runTimeout();
        runSeq(3'd2, 1'b1, 8'h04, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 3, 1'b0);
        runReset();
        runSeq(3'd2, 1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3, 1'b0);
        runSeq(3'd2, 1'b1, 8'h04, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 3, 1'b0);
        runSeq(3'd2, 1'b1, 8'h04, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3, 1'b0);
        runSeq(3'd6, 1'b1, 8'h40, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, GAP, 1'b0);
        runSeq(3'd3, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 2, 1'b1);
        runSeq(3'd0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1, 1'b0);
        runSeq(3'd7, 1'b1, 8'h80, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 3, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard drain: actual %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
